led_fade_pwm: RTL
=================

// Module: led_fade_pwm
// PURPOSE
//  Downstream output stage for the 12-LED pattern generator: consumes its led[11:0] pattern and drives
//  the board LED pins through per-channel PWM with a brightness fade.
//  Each channel ramps up toward full while its input bit is 1 and ramps down toward off while it is 0.
//  Pattern steps therefore appear as smooth fades instead of hard switching.
//  Sits between the pattern generator and the top-level LED pins; runs on the 50MHz board clock.
// PARAMETERS
//  N_LED     12   number of LED channels
//  PWM_BITS  8    PWM counter / brightness width; MAX = 2^PWM_BITS-1
//  FADE_DIV  195  clk cycles per fade tick (>=2)
//  STEP      8    brightness change per fade tick (1..MAX)
// PORTS
//  clk      in   1      50MHz board clock
//  rst      in   1      synchronous, active-low reset
//  led_in   in   N_LED  target pattern from generator (divided-clock domain, treated as async)
//  enable   in   1      0 = blank all outputs; fading continues internally
//  led_out  out  N_LED  PWM drive to LED pins, registered
//  busy     out  1      1 while any channel brightness != its target level, registered
// BEHAVIOUR
//  - Reset (rst==0 at posedge clk): sync flops, pwm_cnt, div_cnt, bri[*], led_out, busy all 0. Applies mid-fade; no partial state is kept.
//  - Input sync: led_in passes through 2 flops -> tgt[N_LED-1:0]. A led_in change is visible in tgt 2 clk later.
//  - pwm_cnt: free-running PWM_BITS counter, +1 every clk, wraps MAX->0.
//  - div_cnt: counts 0..FADE_DIV-1, then wraps to 0.
//    tick is a 1-clk pulse when div_cnt==FADE_DIV-1; the first tick is FADE_DIV clk after reset release.
//  - On tick, per channel i:
//    - tgt[i]==1: bri[i] <= min(bri[i]+STEP, MAX).
//    - tgt[i]==0: bri[i] <= max(bri[i]-STEP, 0).
//    - Saturating arithmetic; compute in PWM_BITS+1 bits; never wraps.
//    - No change between ticks; a tgt change mid-fade reverses direction at the next tick.
//  - duty[i] = bri[i] (see CONFIGURATION).
//  - led_out[i] <= enable & ((bri[i]==MAX) | (duty[i] > pwm_cnt)).
//    - bri==MAX: constant on. bri==0: constant off.
//    - Otherwise high for exactly duty[i] of every 2^PWM_BITS clk.
//    - Latency: 1 clk from bri/pwm_cnt/enable to led_out.
//  - busy <= OR over i of (bri[i] != (tgt[i] ? MAX : 0)), evaluated on the post-update bri.
//  - enable only gates outputs; bri, tgt and counters keep running while enable==0.
// CONFIGURATION
//  LED_FADE_GAMMA_EN defined:
//    - duty[i] = (bri[i]*bri[i]) >> PWM_BITS (square-law perceptual curve; 2*PWM_BITS-bit product).
//    - The bri==MAX full-on override still applies.
//  LED_FADE_GAMMA_EN undefined: duty[i] = bri[i] (linear); no multiplier is synthesized.
// TESTING  (bench params: N_LED=12, PWM_BITS=8, FADE_DIV=4, STEP=64; linear unless stated)
//  1. rst=0 for 3 clk with led_in=12'hfff, enable=1
//     -> led_out==0 and busy==0 during reset; bri all 0; first tick 4 clk after release.
//  2. led_in 12'h000->12'h001, hold
//     -> bri[0] steps 64,128,192,255 on successive ticks (saturates, no wrap).
//     -> busy=1 from the first tick-capable cycle after tgt[0]=1 until bri[0]==255, then 0.
//     -> other channels stay 0.
//  3. Force bri[0]=128 steady (tgt oscillation avoided by sampling between ticks, or FADE_DIV large)
//     -> led_out[0] high exactly 128 of each 256-clk pwm period.
//  4. led_in 12'h001->12'h000 with bri[0]=255
//     -> bri[0] 191,127,63,0 on successive ticks; led_out[0] constantly 0 after reaching 0.
//  5. enable 1->0 mid-fade
//     -> led_out==0 one clk later; bri continues stepping.
//     -> enable back to 1 resumes PWM at the current bri.
//  6. LED_FADE_GAMMA_EN defined, bri[0]=128
//     -> led_out[0] high 64 of 256 clk; bri=255 -> constant high.
//     -> rst=0 mid-fade -> all state and outputs 0 next clk.

Source files
------------

// File: rtl/led_fade_if.sv
// ---------------------------------------------------------------------------
// led_fade_if
// Bundles the pattern/enable inputs and the LED drive/status outputs of the
// LED fade PWM stage.
//   led_in  [N_LED] : target on/off pattern from the pattern generator
//   enable          : 0 blanks every LED output
//   led_out [N_LED] : PWM drive toward the LED pins
//   busy            : some channel has not yet reached its target level
// master : the side that supplies the pattern (generator / testbench)
// slave  : the fade PWM stage itself
// ---------------------------------------------------------------------------
interface led_fade_if #(
    parameter int N_LED = 12
);
    logic [N_LED-1:0] led_in;
    logic             enable;
    logic [N_LED-1:0] led_out;
    logic             busy;

    modport master (
        output led_in,
        output enable,
        input  led_out,
        input  busy
    );

    modport slave (
        input  led_in,
        input  enable,
        output led_out,
        output busy
    );
endinterface

// File: rtl/led_fade_pwm.sv
// ---------------------------------------------------------------------------
// led_fade_pwm
// Output stage between the 12-LED pattern generator and the board LED pins.
// Every channel carries a brightness level that ramps toward full while its
// pattern bit is 1 and toward off while it is 0. The level sets the duty cycle
// of a free-running PWM, so pattern steps appear as smooth fades.
//
// Ports
//   clk        : 50 MHz board clock
//   rst        : synchronous, active-low reset
//   bus.led_in : target pattern (from a divided clock domain, treated as async)
//   bus.enable : 0 blanks all outputs; fading carries on internally
//   bus.led_out: registered PWM drive, one bit per LED
//   bus.busy   : registered, 1 while any brightness differs from its target
//
// Parameters
//   N_LED    : number of channels
//   PWM_BITS : PWM counter / brightness width, MAX = 2^PWM_BITS-1
//   FADE_DIV : clk cycles per fade tick (>= 2)
//   STEP     : brightness change per fade tick (1..MAX)
//
// Build option
//   LED_FADE_GAMMA_EN : when defined, duty = (bri*bri) >> PWM_BITS, a
//                       square-law perceptual curve. When undefined, duty is
//                       the brightness itself and no multiplier exists.
//                       In both cases a full-brightness channel is held
//                       constantly on.
// ---------------------------------------------------------------------------
module led_fade_pwm #(
    parameter int N_LED    = 12,
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 195,
    parameter int STEP     = 8
) (
    input  logic     clk,
    input  logic     rst,
    led_fade_if.slave bus
);

    localparam int                  DIV_W    = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX_V    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ZERO_V   = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS+1)'(STEP);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);

    // Saturating step up: the sum is formed one bit wider so it can never wrap.
    function automatic logic [PWM_BITS-1:0] sat_up(input logic [PWM_BITS-1:0] b);
        logic [PWM_BITS:0] s;
        s = {1'b0, b} + STEP_W;
        if (s > {1'b0, MAX_V}) begin
            return MAX_V;
        end else begin
            return s[PWM_BITS-1:0];
        end
    endfunction

    // Saturating step down: a borrow into the extra top bit means "below zero".
    function automatic logic [PWM_BITS-1:0] sat_dn(input logic [PWM_BITS-1:0] b);
        logic [PWM_BITS:0] d;
        d = {1'b0, b} - STEP_W;
        if (d[PWM_BITS]) begin
            return ZERO_V;
        end else begin
            return d[PWM_BITS-1:0];
        end
    endfunction

    logic [N_LED-1:0]    sync1_r;
    logic [N_LED-1:0]    tgt_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [DIV_W-1:0]    div_cnt_r;
    logic                tick_s;
    logic [PWM_BITS-1:0] bri_r     [N_LED];
    logic [PWM_BITS-1:0] bri_nxt_s [N_LED];
    logic [N_LED-1:0]    on_s;
    logic                busy_nxt_s;
    logic [N_LED-1:0]    led_out_r;
    logic                busy_r;

    assign bus.led_out = led_out_r;
    assign bus.busy    = busy_r;

    // Two-flop synchroniser for the pattern coming from the slower domain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= {N_LED{1'b0}};
            tgt_r   <= {N_LED{1'b0}};
        end else begin
            sync1_r <= bus.led_in;
            tgt_r   <= sync1_r;
        end
    end

    // Free-running PWM counter and fade-tick divider.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_cnt_r <= ZERO_V;
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            if (tick_s) begin
                div_cnt_r <= {DIV_W{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
        end
    end

    // Fade tick: one cycle in every FADE_DIV, the last count of the divider.
    always_comb begin
        tick_s = (div_cnt_r == DIV_LAST);
    end

    // Next brightness per channel; it only moves on a tick, toward the target.
    always_comb begin
        for (int i = 0; i < N_LED; i++) begin
            bri_nxt_s[i] = bri_r[i];
            if (tick_s) begin
                if (tgt_r[i]) begin
                    bri_nxt_s[i] = sat_up(bri_r[i]);
                end else begin
                    bri_nxt_s[i] = sat_dn(bri_r[i]);
                end
            end else begin
                bri_nxt_s[i] = bri_r[i];
            end
        end
    end

    // Busy looks at the brightness being loaded this cycle, so it drops in
    // the same cycle the last channel lands on its target.
    always_comb begin
        busy_nxt_s = 1'b0;
        for (int i = 0; i < N_LED; i++) begin
            if (bri_nxt_s[i] != (tgt_r[i] ? MAX_V : ZERO_V)) begin
                busy_nxt_s = 1'b1;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
        end
    end

    // Brightness registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_LED; i++) begin
                bri_r[i] <= ZERO_V;
            end
        end else begin
            for (int i = 0; i < N_LED; i++) begin
                bri_r[i] <= bri_nxt_s[i];
            end
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_s [N_LED];

    // Square-law duty; the comparison stays at full product width so the
    // top half of the shifted product takes part in it.
    always_comb begin
        on_s = {N_LED{1'b0}};
        for (int i = 0; i < N_LED; i++) begin
            duty_s[i] = ({{PWM_BITS{1'b0}}, bri_r[i]} * {{PWM_BITS{1'b0}}, bri_r[i]}) >> PWM_BITS;
            on_s[i]   = (bri_r[i] == MAX_V) | (duty_s[i] > {{PWM_BITS{1'b0}}, pwm_cnt_r});
        end
    end
`else
    // Linear duty. Full brightness is forced on because duty > pwm_cnt
    // can never hold when pwm_cnt reaches MAX.
    always_comb begin
        on_s = {N_LED{1'b0}};
        for (int i = 0; i < N_LED; i++) begin
            on_s[i] = (bri_r[i] == MAX_V) | (bri_r[i] > pwm_cnt_r);
        end
    end
`endif

    // Registered outputs; enable only blanks the drive, nothing else.
    always_ff @(posedge clk) begin
        if (!rst) begin
            led_out_r <= {N_LED{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            led_out_r <= {N_LED{bus.enable}} & on_s;
            busy_r    <= busy_nxt_s;
        end
    end

endmodule
